sys_irq_ctrl: RTL and testbench

- OPB slave interrupt controller that implements the system interrupt chain.
- Synchronises 16 application interrupt sources and latches them as pending per a per-source edge/level config.
- Gates pending sources with an enable mask and drives the single active-low irq_n to the CPU, with a programmable hold-off after each acknowledge.
- Sits beside the system register block on the same OPB and replaces its tied-high irq_n.

---
 rtl/sys_irq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_sys_irq_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_irq_ctrl.sv
// OPB slave interrupt controller: synchronises 16 sources, latches them as pending
// (edge or level per source), masks them and drives irq_n with a post-ACK hold-off.
// Optional build macro SYS_IRQ_SOFTSET_EN adds the SOFTSET (write-1-set) register 6.
`timescale 1ns/1ps

module sys_irq_ctrl #(
    parameter logic [31:0] C_BASEADDR     = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR     = 32'h0000_FFFF,
    parameter int          C_OPB_AWIDTH   = 32,
    parameter int          C_OPB_DWIDTH   = 32,
    parameter int          HOLDOFF_CYCLES = 8
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [15:0]             app_irq,
    output logic                    irq_n,
    output logic [4:0]              irq_vec
);

    localparam logic [3:0] REG_RAW     = 4'd0;
    localparam logic [3:0] REG_PEND    = 4'd1;
    localparam logic [3:0] REG_ENABLE  = 4'd2;
    localparam logic [3:0] REG_ACK     = 4'd3;
    localparam logic [3:0] REG_MODE    = 4'd4;
    localparam logic [3:0] REG_ACTIVE  = 4'd5;
`ifdef SYS_IRQ_SOFTSET_EN
    localparam logic [3:0] REG_SOFTSET = 4'd6;
`endif

    localparam logic [C_OPB_AWIDTH-1:0] BASE = C_OPB_AWIDTH'(C_BASEADDR);
    localparam logic [C_OPB_AWIDTH-1:0] SPAN = C_OPB_AWIDTH'(C_HIGHADDR - C_BASEADDR);
    localparam logic [7:0]              HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_HOLDOFF} state_t;

    logic [C_OPB_AWIDTH-1:0] a_trans;
    logic                    a_match, start, wr, ack_wr, any_active;
    logic [3:0]              reg_sel;
    logic [15:0]             wdata, be_mask, ack_clr, soft_set;
    logic [15:0]             sync1, sync2, sync3, rise;
    logic [15:0]             pend, pend_next, enable, mode, active;
    logic [4:0]              vec_next;
    logic [C_OPB_DWIDTH-1:0] rd_data;
    logic [7:0]              cnt;
    state_t                  state;
    logic                    unused_ok;

    // Addresses below the base wrap to large offsets, so one compare covers the window.
    assign a_trans = OPB_ABus - BASE;
    assign a_match = (a_trans <= SPAN);
    assign reg_sel = a_trans[5:2];
    assign start   = a_match & OPB_select & ~Sl_xferAck;
    assign wr      = start & ~OPB_RNW;
    assign wdata   = OPB_DBus[16:31];
    assign be_mask = {{8{OPB_BE[2]}}, {8{OPB_BE[3]}}};
    assign ack_wr  = wr && (reg_sel == REG_ACK);
    assign ack_clr = ack_wr ? (wdata & be_mask) : '0;

`ifdef SYS_IRQ_SOFTSET_EN
    assign soft_set = (wr && reg_sel == REG_SOFTSET) ? (wdata & be_mask) : '0;
`else
    assign soft_set = '0;
`endif

    assign rise       = sync2 & ~sync3;
    // Set terms sit outside the clear mask, so a coincident set always wins over ACK.
    assign pend_next  = (mode & (rise | soft_set | (pend & ~ack_clr))) | (~mode & sync2);
    assign active     = pend & enable;
    assign any_active = |active;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign unused_ok  = ^{OPB_seqAddr, OPB_BE[0:1], OPB_DBus[0:15],
                          a_trans[C_OPB_AWIDTH-1:6], a_trans[1:0]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        vec_next = '0;
        for (int i = 15; i >= 0; i--) begin
            if (active[i]) vec_next = {1'b1, 4'(i)};
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_RAW:    rd_data = {16'b0, sync2};
            REG_PEND:   rd_data = {16'b0, pend};
            REG_ENABLE: rd_data = {16'b0, enable};
            REG_MODE:   rd_data = {16'b0, mode};
            REG_ACTIVE: rd_data = {11'b0, irq_vec, active};
            default:    rd_data = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            sync1      <= '0;
            sync2      <= '0;
            sync3      <= '0;
            pend       <= '0;
            enable     <= '0;
            mode       <= 16'hFFFF;
            Sl_xferAck <= 1'b0;
            Sl_DBus    <= '0;
            irq_vec    <= '0;
        end else begin
            sync1      <= app_irq;
            sync2      <= sync1;
            sync3      <= sync2;
            pend       <= pend_next;
            if (wr && reg_sel == REG_ENABLE) enable <= (enable & ~be_mask) | (wdata & be_mask);
            if (wr && reg_sel == REG_MODE)   mode   <= (mode & ~be_mask) | (wdata & be_mask);
            Sl_xferAck <= start;
            Sl_DBus    <= (start && OPB_RNW) ? rd_data : '0;
            irq_vec    <= vec_next;
        end
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            state <= ST_IDLE;
            irq_n <= 1'b1;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_active) begin
                        state <= ST_ASSERT;
                        irq_n <= 1'b0;
                    end
                end
                ST_ASSERT: begin
                    if (ack_wr) begin
                        state <= ST_HOLDOFF;
                        irq_n <= 1'b1;
                        cnt   <= HOLD_LOAD;
                    end else if (!any_active) begin
                        state <= ST_IDLE;
                        irq_n <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == 8'd0) begin
                        state <= any_active ? ST_ASSERT : ST_IDLE;
                        irq_n <= ~any_active;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    irq_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sys_irq_ctrl.sv
// Directed self-checking bench for sys_irq_ctrl: register access, edge/level pending,
// hold-off timing, ACK/set collisions, byte enables and asynchronous reset.
`timescale 1ns/1ps

module tb_sys_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus;
    logic        rnw, select, seq_addr;
    logic [0:31] sl_dbus;
    logic        sl_ack, sl_err, sl_retry, sl_tout;
    logic [15:0] app_irq;
    logic        irq_n;
    logic [4:0]  irq_vec;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sys_irq_ctrl dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .OPB_ABus    (abus),
        .OPB_BE      (be),
        .OPB_DBus    (dbus),
        .OPB_RNW     (rnw),
        .OPB_select  (select),
        .OPB_seqAddr (seq_addr),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (sl_ack),
        .Sl_errAck   (sl_err),
        .Sl_retry    (sl_retry),
        .Sl_toutSup  (sl_tout),
        .app_irq     (app_irq),
        .irq_n       (irq_n),
        .irq_vec     (irq_vec)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd_check(input string tag, input logic [3:0] r, input logic [31:0] exp);
        abus   = {26'b0, r, 2'b00};
        rnw    = 1'b1;
        select = 1'b1;
        step();
        check({tag, "_ack"}, 32'(sl_ack), 32'd1);
        check(tag, 32'(sl_dbus), exp);
        select = 1'b0;
        rnw    = 1'b0;
        step();
    endtask

    task automatic opb_write(input logic [3:0] r, input logic [15:0] data, input logic [3:0] bes);
        abus   = {26'b0, r, 2'b00};
        dbus   = {16'b0, data};
        be     = bes;
        rnw    = 1'b0;
        select = 1'b1;
        step();
        check("wr_ack", 32'(sl_ack), 32'd1);
        select = 1'b0;
        be     = 4'b0000;
        step();
    endtask

    initial begin
        rst = 1'b1; abus = '0; be = '0; dbus = '0; rnw = 1'b0; select = 1'b0;
        seq_addr = 1'b0; app_irq = '0;
        step(2);
        check("rst_irq_n", 32'(irq_n), 32'd1);
        check("rst_ack", 32'(sl_ack), 32'd0);
        check("rst_dbus", 32'(sl_dbus), 32'd0);
        check("rst_vec", 32'(irq_vec), 32'd0);
        rst = 1'b0;
        step();

        rd_check("raw0", 4'd0, 32'h0);
        rd_check("pend0", 4'd1, 32'h0);
        rd_check("enable0", 4'd2, 32'h0);
        rd_check("ack_reads0", 4'd3, 32'h0);
        rd_check("mode0", 4'd4, 32'h0000_FFFF);
        rd_check("active0", 4'd5, 32'h0);
        rd_check("reg6_0", 4'd6, 32'h0);
        rd_check("reg7_0", 4'd7, 32'h0);
        check("idle_irq_n", 32'(irq_n), 32'd1);

        // select held high: acks alternate, never back-to-back
        abus = '0; rnw = 1'b1; select = 1'b1;
        step();  check("b2b_ack1", 32'(sl_ack), 32'd1);
        step();  check("b2b_gap", 32'(sl_ack), 32'd0);
        check("b2b_gap_dbus", 32'(sl_dbus), 32'd0);
        step();  check("b2b_ack2", 32'(sl_ack), 32'd1);
        select = 1'b0; rnw = 1'b0;
        step();  check("b2b_idle", 32'(sl_ack), 32'd0);

        // address outside the window is never acknowledged
        abus = 32'h0001_0008; rnw = 1'b1; select = 1'b1;
        step();  check("oor_ack1", 32'(sl_ack), 32'd0);
        step();  check("oor_ack2", 32'(sl_ack), 32'd0);
        select = 1'b0; rnw = 1'b0;
        step();

        // edge source 2, one-cycle pulse
        opb_write(4'd2, 16'h0005, 4'b1111);
        app_irq = 16'h0004;
        step();
        app_irq = 16'h0000;
        step(2);
        check("edge2_irq_n_early", 32'(irq_n), 32'd1);
        check("edge2_vec_early", 32'(irq_vec), 32'd0);
        step();
        check("edge2_irq_n", 32'(irq_n), 32'd0);
        check("edge2_vec", 32'(irq_vec), 32'h12);
        rd_check("edge2_pend", 4'd1, 32'h0000_0004);
        rd_check("edge2_active", 4'd5, 32'h0012_0004);

        // ACK then a new edge during hold-off
        opb_write(4'd3, 16'h0004, 4'b1111);
        check("ack_irq_n", 32'(irq_n), 32'd1);
        check("ack_vec", 32'(irq_vec), 32'd0);
        app_irq = 16'h0001;
        for (int k = 2; k <= 7; k++) begin
            step();
            if (k == 2) app_irq = 16'h0000;
            check("holdoff_high", 32'(irq_n), 32'd1);
        end
        step();
        check("holdoff_end_irq_n", 32'(irq_n), 32'd0);
        check("holdoff_end_vec", 32'(irq_vec), 32'h10);
        rd_check("holdoff_pend", 4'd1, 32'h0000_0001);

        // level mode on source 0
        opb_write(4'd3, 16'h0001, 4'b1111);
        opb_write(4'd4, 16'hFFFE, 4'b1111);
        opb_write(4'd2, 16'h0001, 4'b1111);
        step(10);
        check("lvl_idle_irq_n", 32'(irq_n), 32'd1);
        rd_check("lvl_mode", 4'd4, 32'h0000_FFFE);
        app_irq = 16'h0001;
        step(3);
        check("lvl_irq_n_early", 32'(irq_n), 32'd1);
        step();
        check("lvl_irq_n", 32'(irq_n), 32'd0);
        rd_check("lvl_pend", 4'd1, 32'h0000_0001);
        rd_check("lvl_raw", 4'd0, 32'h0000_0001);
        opb_write(4'd3, 16'h0001, 4'b1111);
        check("lvl_ack_holdoff", 32'(irq_n), 32'd1);
        rd_check("lvl_pend_after_ack", 4'd1, 32'h0000_0001);
        step(8);
        check("lvl_reassert", 32'(irq_n), 32'd0);
        app_irq = 16'h0000;
        step(3);
        check("lvl_drop_irq_n_early", 32'(irq_n), 32'd0);
        step();
        check("lvl_drop_irq_n", 32'(irq_n), 32'd1);
        rd_check("lvl_drop_pend", 4'd1, 32'h0);

        // edge on source 3 lands in the same cycle as its ACK
        app_irq = 16'h0008;
        step(2);
        opb_write(4'd3, 16'h0008, 4'b1111);
        rd_check("set_wins_pend", 4'd1, 32'h0000_0008);
        opb_write(4'd3, 16'h0008, 4'b1111);
        rd_check("plain_ack_pend", 4'd1, 32'h0);
        app_irq = 16'h0000;

        // byte enables
        opb_write(4'd2, 16'hFFFF, 4'b0001);
        rd_check("be3_enable", 4'd2, 32'h0000_00FF);
        opb_write(4'd2, 16'hAB00, 4'b0010);
        rd_check("be2_enable", 4'd2, 32'h0000_ABFF);
        opb_write(4'd2, 16'h1234, 4'b1100);
        rd_check("be01_enable", 4'd2, 32'h0000_ABFF);
        opb_write(4'd7, 16'hFFFF, 4'b1111);
        rd_check("reg7_wr_ignored", 4'd7, 32'h0);

        // soft set on an edge-mode bit
        opb_write(4'd6, 16'h0010, 4'b1111);
`ifdef SYS_IRQ_SOFTSET_EN
        rd_check("softset_pend", 4'd1, 32'h0000_0010);
`else
        rd_check("softset_pend", 4'd1, 32'h0);
`endif
        rd_check("softset_reads0", 4'd6, 32'h0);
        opb_write(4'd3, 16'h0010, 4'b1111);
        opb_write(4'd2, 16'h0001, 4'b1111);

        // reset in the middle of ASSERT and of a read
        app_irq = 16'h0001;
        step(12);
        check("pre_rst_irq_n", 32'(irq_n), 32'd0);
        abus = {26'b0, 4'd2, 2'b00}; rnw = 1'b1; select = 1'b1;
        step();
        check("pre_rst_ack", 32'(sl_ack), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_irq_n", 32'(irq_n), 32'd1);
        check("async_rst_ack", 32'(sl_ack), 32'd0);
        check("async_rst_dbus", 32'(sl_dbus), 32'd0);
        check("async_rst_vec", 32'(irq_vec), 32'd0);
        app_irq = 16'h0020;
        step();
        check("in_rst_ack", 32'(sl_ack), 32'd0);
        select = 1'b0; rnw = 1'b0;
        step();
        rst = 1'b0;
        step(4);
        rd_check("post_rst_raw", 4'd0, 32'h0000_0020);
        rd_check("post_rst_pend", 4'd1, 32'h0000_0020);
        rd_check("post_rst_enable", 4'd2, 32'h0);
        rd_check("post_rst_mode", 4'd4, 32'h0000_FFFF);
        check("post_rst_irq_n", 32'(irq_n), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
